naneye_frame_ctrl: RTL and testbench

- Frame-level controller downstream of the NanEye bit-stream decoder. It consumes the decoded bit stream (S_DATA qualified by S_WREN) and the CON_ZERO frame-gap flag.
- It sequences frame synchronisation and deserialises start/data/stop framed pixel words. It tracks row and column position.
- It hands pixels to the frame buffer over a valid/ready interface. Framing and overflow faults are reported as sticky error flags.

---
 rtl/naneye_pkg.sv | 23 ++
 rtl/naneye_pix_deser.sv | 48 ++++
 rtl/naneye_frame_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_naneye_frame_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/naneye_pkg.sv
// Shared definitions for the NanEye frame path: FSM states, error-flag
// positions and the default sensor geometry used by decoder and controller.
package naneye_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FS    = 3'd1,
        WAIT_START = 3'd2,
        DATA       = 3'd3,
        STOP       = 3'd4
    } state_e;

    localparam int ERR_FRAMING_BIT = 0;
    localparam int ERR_SHORT_BIT   = 1;
    localparam int ERR_OVF_BIT     = 2;
    localparam int ERR_N           = 3;

    localparam int NANEYE_PIX_W = 12;
    localparam int NANEYE_COLS  = 250;
    localparam int NANEYE_ROWS  = 250;
    localparam int NANEYE_IDX_W = 8;

endpackage

// File: rtl/naneye_pix_deser.sv
// MSB-first pixel deserialiser: shifts one bit per strobe until PIX_W bits are
// collected; the word stays in the shift register until the next word starts.
module naneye_pix_deser #(
    parameter int PIX_W = naneye_pkg::NANEYE_PIX_W
) (
    input  logic             SCLOCK,
    input  logic             RESET,
    input  logic             s_data_i,
    input  logic             s_wren_i,
    input  logic             clear_i,
    output logic [PIX_W-1:0] word_o,
    output logic             word_done_o
);

    localparam int CNT_W = $clog2(PIX_W + 1);

    logic [PIX_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shift register and bit counter state
    always_ff @(posedge SCLOCK or negedge RESET) begin
        if (!RESET) begin
            sr_q  <= {PIX_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // Clear only rewinds the counter so the finished word remains readable
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (s_wren_i && (cnt_q < CNT_W'(PIX_W))) begin
            sr_d  = {sr_q[PIX_W-2:0], s_data_i};
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign word_o      = sr_q;
    assign word_done_o = s_wren_i && !clear_i && (cnt_q == CNT_W'(PIX_W - 1));

endmodule

// File: rtl/naneye_frame_ctrl.sv
// NanEye frame controller: frame sync on CON_ZERO, start/data/stop word
// framing, row/column tracking, valid/ready pixel output and sticky errors.
module naneye_frame_ctrl #(
    parameter int PIX_W = naneye_pkg::NANEYE_PIX_W,
    parameter int COLS  = naneye_pkg::NANEYE_COLS,
    parameter int ROWS  = naneye_pkg::NANEYE_ROWS,
    parameter int IDX_W = naneye_pkg::NANEYE_IDX_W
) (
    input  logic             SCLOCK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             S_DATA,
    input  logic             S_WREN,
    input  logic             CON_ZERO,
    output logic [PIX_W-1:0] PIX_DATA,
    output logic             PIX_VALID,
    input  logic             PIX_READY,
    output logic [IDX_W-1:0] ROW_IDX,
    output logic [IDX_W-1:0] COL_IDX,
    output logic             FRAME_START,
    output logic             FRAME_END,
    output logic [15:0]      FRAME_CNT,
    output logic             ERR_FRAMING,
    output logic             ERR_SHORT,
    output logic             ERR_OVF,
    input  logic             ERR_CLR
);

    import naneye_pkg::*;

    localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);
    localparam logic [IDX_W-1:0] ROW_LAST = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    state_e             state_q, state_d;
    logic               con_zero_q;
    logic [IDX_W-1:0]   col_q, col_d, row_q, row_d;
    logic [PIX_W-1:0]   pix_data_q, pix_data_d;
    logic               pix_valid_q, pix_valid_d;
    logic [IDX_W-1:0]   row_idx_q, row_idx_d, col_idx_q, col_idx_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_end_q, frame_end_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [ERR_N-1:0]   err_q, err_d, err_set;
    logic               deser_clear, short_ev;
    logic [PIX_W-1:0]   word;
    logic               word_done;
    logic               cz_rise, cz_fall, last_pix;

    assign cz_rise  = CON_ZERO && !con_zero_q;
    assign cz_fall  = !CON_ZERO && con_zero_q;
    assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

    naneye_pix_deser #(.PIX_W(PIX_W)) u_deser (
        .SCLOCK      (SCLOCK),
        .RESET       (RESET),
        .s_data_i    (S_DATA),
        .s_wren_i    (S_WREN),
        .clear_i     (deser_clear),
        .word_o      (word),
        .word_done_o (word_done)
    );

    // State, position, output and error registers
    always_ff @(posedge SCLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= IDLE;
            con_zero_q    <= 1'b0;
            col_q         <= IDX_ZERO;
            row_q         <= IDX_ZERO;
            pix_data_q    <= {PIX_W{1'b0}};
            pix_valid_q   <= 1'b0;
            row_idx_q     <= IDX_ZERO;
            col_idx_q     <= IDX_ZERO;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_cnt_q   <= 16'd0;
            err_q         <= {ERR_N{1'b0}};
        end else begin
            state_q       <= state_d;
            con_zero_q    <= CON_ZERO;
            col_q         <= col_d;
            row_q         <= row_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            row_idx_q     <= row_idx_d;
            col_idx_q     <= col_idx_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_cnt_q   <= frame_cnt_d;
            err_q         <= err_d;
        end
    end

    // Next-state logic; a stop-phase strobe is resolved before a frame-gap abort
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        pix_data_d    = pix_data_q;
        pix_valid_d   = pix_valid_q && !PIX_READY;
        row_idx_d     = row_idx_q;
        col_idx_d     = col_idx_q;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_set       = {ERR_N{1'b0}};
        deser_clear   = 1'b1;
        short_ev      = 1'b0;

        if (!EN) begin
            state_d     = IDLE;
            col_d       = IDX_ZERO;
            row_d       = IDX_ZERO;
            pix_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: state_d = WAIT_FS;
                WAIT_FS: begin
                    if (cz_fall) begin
                        frame_start_d = 1'b1;
                        col_d         = IDX_ZERO;
                        row_d         = IDX_ZERO;
                        state_d       = WAIT_START;
                    end else begin
                        state_d = WAIT_FS;
                    end
                end
                WAIT_START: begin
                    if (cz_rise) begin
                        short_ev = 1'b1;
                    end else if (S_WREN && S_DATA) begin
                        state_d = DATA;
                    end else begin
                        state_d = WAIT_START;
                    end
                end
                DATA: begin
                    deser_clear = 1'b0;
                    if (cz_rise) begin
                        short_ev = 1'b1;
                    end else if (word_done) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end
                STOP: begin
                    if (S_WREN && !S_DATA) begin
                        pix_data_d  = word;
                        row_idx_d   = row_q;
                        col_idx_d   = col_q;
                        pix_valid_d = 1'b1;
                        err_set[ERR_OVF_BIT] = pix_valid_q && !PIX_READY;
                        if (col_q == COL_LAST) begin
                            col_d = IDX_ZERO;
                            row_d = last_pix ? IDX_ZERO : row_q + IDX_ONE;
                        end else begin
                            col_d = col_q + IDX_ONE;
                        end
                        if (last_pix) begin
                            frame_end_d = 1'b1;
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            state_d     = WAIT_FS;
                        end else begin
                            state_d  = WAIT_START;
                            short_ev = cz_rise;
                        end
                    end else if (S_WREN) begin
                        err_set[ERR_FRAMING_BIT] = 1'b1;
                        state_d  = WAIT_START;
                        short_ev = cz_rise;
                    end else begin
                        short_ev = cz_rise;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (short_ev) begin
                err_set[ERR_SHORT_BIT] = 1'b1;
                frame_end_d = 1'b1;
                state_d     = WAIT_FS;
            end else begin
                frame_end_d = frame_end_d;
            end
        end

        err_d = (err_q & ~{ERR_N{ERR_CLR}}) | err_set;
    end

    assign PIX_DATA    = pix_data_q;
    assign PIX_VALID   = pix_valid_q;
    assign ROW_IDX     = row_idx_q;
    assign COL_IDX     = col_idx_q;
    assign FRAME_START = frame_start_q;
    assign FRAME_END   = frame_end_q;
    assign FRAME_CNT   = frame_cnt_q;
    assign ERR_FRAMING = err_q[ERR_FRAMING_BIT];
    assign ERR_SHORT   = err_q[ERR_SHORT_BIT];
    assign ERR_OVF     = err_q[ERR_OVF_BIT];

endmodule

// File: tb/tb_naneye_frame_ctrl.sv
// Directed bench for naneye_frame_ctrl on a 2x2 frame; accepted pixels are
// checked against a queue of expected (data,row,col) entries.
module tb_naneye_frame_ctrl;

    localparam int PIX_W = 12;
    localparam int IDX_W = 8;

    typedef struct packed {
        logic [PIX_W-1:0] d;
        logic [IDX_W-1:0] r;
        logic [IDX_W-1:0] c;
    } pix_t;

    logic             SCLOCK = 1'b0;
    logic             RESET, EN, S_DATA, S_WREN, CON_ZERO, PIX_READY, ERR_CLR;
    logic [PIX_W-1:0] PIX_DATA;
    logic             PIX_VALID, FRAME_START, FRAME_END;
    logic [IDX_W-1:0] ROW_IDX, COL_IDX;
    logic [15:0]      FRAME_CNT;
    logic             ERR_FRAMING, ERR_SHORT, ERR_OVF;

    int   errors = 0;
    int   checks = 0;
    pix_t sb_q[$];

    naneye_frame_ctrl #(.PIX_W(PIX_W), .COLS(2), .ROWS(2), .IDX_W(IDX_W)) dut (
        .SCLOCK(SCLOCK), .RESET(RESET), .EN(EN), .S_DATA(S_DATA), .S_WREN(S_WREN),
        .CON_ZERO(CON_ZERO), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
        .PIX_READY(PIX_READY), .ROW_IDX(ROW_IDX), .COL_IDX(COL_IDX),
        .FRAME_START(FRAME_START), .FRAME_END(FRAME_END), .FRAME_CNT(FRAME_CNT),
        .ERR_FRAMING(ERR_FRAMING), .ERR_SHORT(ERR_SHORT), .ERR_OVF(ERR_OVF),
        .ERR_CLR(ERR_CLR)
    );

    always #5 SCLOCK = ~SCLOCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after each rising edge
    task automatic step();
        @(posedge SCLOCK);
        #2;
    endtask

    task automatic send_bit(input logic b);
        S_DATA = b;
        S_WREN = 1'b1;
        step();
        S_WREN = 1'b0;
    endtask

    task automatic send_word(input logic [PIX_W-1:0] w, input logic stop_bit);
        send_bit(1'b1);
        for (int i = PIX_W - 1; i >= 0; i--) send_bit(w[i]);
        send_bit(stop_bit);
    endtask

    task automatic good_word(input logic [PIX_W-1:0] w, input int r, input int c);
        pix_t e;
        e.d = w;
        e.r = IDX_W'(r);
        e.c = IDX_W'(c);
        sb_q.push_back(e);
        send_word(w, 1'b0);
    endtask

    task automatic start_frame();
        CON_ZERO = 1'b1;
        step();
        step();
        CON_ZERO = 1'b0;
        step();
        chk("frame_start", {31'd0, FRAME_START}, 32'd1);
    endtask

    // Scoreboard: every accepted pixel must match the oldest expected entry
    always @(negedge SCLOCK) begin
        if (PIX_VALID && PIX_READY) begin
            chk("sb_has_entry", {31'd0, (sb_q.size() > 0)}, 32'd1);
            if (sb_q.size() > 0) begin
                pix_t e;
                e = sb_q.pop_front();
                chk("pix_data", {20'd0, PIX_DATA}, {20'd0, e.d});
                chk("pix_row", {24'd0, ROW_IDX}, {24'd0, e.r});
                chk("pix_col", {24'd0, COL_IDX}, {24'd0, e.c});
            end
        end
    end

    initial begin
        RESET = 1'b0; EN = 1'b1; S_DATA = 1'b0; S_WREN = 1'b0;
        CON_ZERO = 1'b1; PIX_READY = 1'b1; ERR_CLR = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, PIX_VALID}, 32'd0);
        chk("rst_cnt", {16'd0, FRAME_CNT}, 32'd0);
        chk("rst_err", {29'd0, ERR_OVF, ERR_SHORT, ERR_FRAMING}, 32'd0);
        chk("rst_data", {20'd0, PIX_DATA}, 32'd0);
        RESET = 1'b1;
        step();
        step();

        // Full 2x2 frame
        start_frame();
        step();
        chk("frame_start_pulse", {31'd0, FRAME_START}, 32'd0);
        good_word(12'hABC, 0, 0);
        chk("pix_valid_lat1", {31'd0, PIX_VALID}, 32'd1);
        good_word(12'h123, 0, 1);
        good_word(12'hFFF, 1, 0);
        chk("no_early_end", {31'd0, FRAME_END}, 32'd0);
        good_word(12'h000, 1, 1);
        chk("end_with_valid", {30'd0, FRAME_END, PIX_VALID}, 32'd3);
        chk("frame_cnt1", {16'd0, FRAME_CNT}, 32'd1);
        step();
        chk("end_pulse", {31'd0, FRAME_END}, 32'd0);

        // Framing error on second word
        start_frame();
        good_word(12'h111, 0, 0);
        send_word(12'h222, 1'b1);
        chk("err_framing", {31'd0, ERR_FRAMING}, 32'd1);
        chk("bad_not_out", {31'd0, PIX_VALID}, 32'd0);
        good_word(12'h333, 0, 1);
        good_word(12'h444, 1, 0);
        good_word(12'h555, 1, 1);
        chk("frame_cnt2", {16'd0, FRAME_CNT}, 32'd2);
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        chk("framing_clr", {31'd0, ERR_FRAMING}, 32'd0);

        // Short frame: gap after three pixels
        start_frame();
        good_word(12'h0F1, 0, 0);
        good_word(12'h0F2, 0, 1);
        good_word(12'h0F3, 1, 0);
        CON_ZERO = 1'b1;
        step();
        chk("short_end", {30'd0, ERR_SHORT, FRAME_END}, 32'd3);
        chk("short_cnt", {16'd0, FRAME_CNT}, 32'd2);
        step();
        CON_ZERO = 1'b0;
        step();
        chk("short_to_wait_fs", {31'd0, FRAME_START}, 32'd1);
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        chk("short_clr", {31'd0, ERR_SHORT}, 32'd0);

        // Overflow with PIX_READY low across two words
        PIX_READY = 1'b0;
        send_word(12'hA5A, 1'b0);
        step();
        step();
        chk("hold_data", {20'd0, PIX_DATA}, 32'h0A5A);
        chk("hold_valid_col", {23'd0, PIX_VALID, COL_IDX}, 32'h100);
        chk("no_ovf_yet", {31'd0, ERR_OVF}, 32'd0);
        good_word(12'h5A5, 0, 1);
        chk("err_ovf", {31'd0, ERR_OVF}, 32'd1);
        chk("ovf_data", {20'd0, PIX_DATA}, 32'h05A5);
        chk("ovf_col", {24'd0, COL_IDX}, 32'd1);
        PIX_READY = 1'b1;
        step();
        chk("valid_falls", {31'd0, PIX_VALID}, 32'd0);
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        chk("ovf_clr", {31'd0, ERR_OVF}, 32'd0);

        // EN dropped mid-word while a pixel is pending
        PIX_READY = 1'b0;
        send_word(12'h777, 1'b0);
        send_bit(1'b1);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        EN = 1'b0;
        step();
        chk("en_drop_valid", {31'd0, PIX_VALID}, 32'd0);
        chk("en_drop_no_end", {31'd0, FRAME_END}, 32'd0);
        PIX_READY = 1'b1;
        EN = 1'b1;
        step();
        step();
        send_word(12'h888, 1'b0);
        step();
        chk("wait_new_fs", {31'd0, PIX_VALID}, 32'd0);

        // Fill bits before a start bit, then finish a clean frame
        start_frame();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        good_word(12'h9C3, 0, 0);
        good_word(12'h246, 0, 1);
        good_word(12'h68A, 1, 0);
        good_word(12'hACE, 1, 1);
        chk("fill_no_err", {29'd0, ERR_OVF, ERR_SHORT, ERR_FRAMING}, 32'd0);
        chk("frame_cnt3", {16'd0, FRAME_CNT}, 32'd3);
        step();
        step();
        chk("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
